// File: rtl/diff_tx_pkg.sv
// Shared types and helpers for the difference-sample frame transmitter.
// Sample words are {phase, data[19:0]}; frames are SYNC, SEQ, N x (B0,B1,B2), CSUM.
package diff_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SEQ,
    SMP,
    CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam int         SPF_DEF         = 4;
  localparam int         FRAME_BYTES     = 3 * SPF_DEF + 3;

  // B0 carries the phase flag in bit 7 and the top nibble of the sample.
  function automatic logic [7:0] sample_byte(input logic [1:0] idx, input logic [20:0] word);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {word[20], 3'b000, word[19:16]};
      2'd1:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/diff_sample_fifo.sv
// Synchronous show-ahead FIFO for captured samples; head is valid whenever level is non-zero.
// Push is ignored when full and pop when empty; full is based on the registered level.
module diff_sample_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      level,
  output logic             full
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/diff_frame_tx.sv
// Captures difference samples on the falling edge of in_dval, buffers them and streams checksummed byte frames.
// A frame starts one cycle after the FIFO holds a full frame's worth; each byte holds until accepted.
module diff_frame_tx
  import diff_tx_pkg::*;
#(
  parameter int         DATA_W            = 20,
  parameter int         FIFO_DEPTH        = 16,
  parameter int         SAMPLES_PER_FRAME = SPF_DEF,
  parameter logic [7:0] SYNC_BYTE         = SYNC_BYTE_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_dval,
  input  logic                          in_phase,
  input  logic                          clr_ovf,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    frame_seq
);

  localparam int          LW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] FRM_LVL  = LW'(SAMPLES_PER_FRAME);
  localparam logic [3:0]  LAST_SMP = 4'(SAMPLES_PER_FRAME - 1);

  logic              dval_q;
  logic              smp_evt;
  logic              push;
  logic              pop;
  logic              full;
  logic [DATA_W:0]   head;
  state_t            state;
  state_t            state_nxt;
  logic [1:0]        byte_idx;
  logic [3:0]        smp_idx;
  logic [7:0]        csum;

  // dval_q resets low so a low in_dval at reset release is not taken as a sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dval_q <= 1'b0;
    end else begin
      dval_q <= in_dval;
    end
  end

  assign smp_evt = ~in_dval & dval_q;
  assign push    = smp_evt & ~full;

  // A sample arriving on a full FIFO is lost even if a pop happens the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (smp_evt & full) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  diff_sample_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({in_phase, in_data}),
    .pop       (pop),
    .head      (head),
    .level     (fifo_level),
    .full      (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level >= FRM_LVL) begin
          state_nxt = SYNC;
        end
      end
      SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) begin
          state_nxt = SEQ;
        end
      end
      SEQ: begin
        tx_valid = 1'b1;
        tx_data  = frame_seq;
        if (tx_ready) begin
          state_nxt = SMP;
        end
      end
      SMP: begin
        tx_valid = 1'b1;
        tx_data  = sample_byte(byte_idx, head);
        if (tx_ready && byte_idx == 2'd2) begin
          pop = 1'b1;
          if (smp_idx == LAST_SMP) begin
            state_nxt = CSUM;
          end
        end
      end
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = 8'd0 - csum;
        if (tx_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx  <= 2'd0;
      smp_idx   <= 4'd0;
      csum      <= 8'd0;
      frame_seq <= 8'd0;
    end else begin
      case (state)
        SYNC: begin
          csum     <= 8'd0;
          byte_idx <= 2'd0;
          smp_idx  <= 4'd0;
        end
        SEQ: begin
          if (tx_ready) begin
            csum <= csum + frame_seq;
          end
        end
        SMP: begin
          if (tx_ready) begin
            csum <= csum + tx_data;
            if (byte_idx == 2'd2) begin
              byte_idx <= 2'd0;
              smp_idx  <= smp_idx + 4'd1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        CSUM: begin
          if (tx_ready) begin
            frame_seq <= frame_seq + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_diff_frame_tx.sv
// Randomised bench for diff_frame_tx: a sample-level model predicts the frame byte stream,
// a monitor consumes it as bytes are accepted and checks handshake and timing rules.
module tb_diff_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] in_data = 20'h0;
  logic        in_dval = 1'b1;
  logic        in_phase = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        ovf;
  logic [4:0]  fifo_level;
  logic [7:0]  frame_seq;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [20:0] pend[$];
  int          ready_mode = 1;

  // model state
  logic [7:0] m_seq = 8'h00;
  int         pushed = 0;
  int         popped = 0;
  int         m_level_q = 0;
  logic       m_ovf = 1'b0;
  logic       prev_dval = 1'b0;

  // monitor state
  int         pos = 0;
  int         frames_done = 0;
  int         fsum = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  logic       prev_valid = 1'b0;
  logic       after_csum = 1'b0;
  logic       saw_ff = 1'b0;
  logic       saw_wrap = 1'b0;

  logic [7:0] t1_bytes [15] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01,
                                8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'hFC};

  diff_frame_tx dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_dval    (in_dval),
    .in_phase   (in_phase),
    .clr_ovf    (clr_ovf),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ovf        (ovf),
    .fifo_level (fifo_level),
    .frame_seq  (frame_seq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Builds the expected frame from four buffered samples using the byte layout rules.
  task automatic gen_frame();
    int s;
    int b;
    exp_q.push_back(8'hA5);
    exp_q.push_back(m_seq);
    s = int'(m_seq);
    for (int k = 0; k < 4; k++) begin
      int w;
      w = int'(pend[k]);
      b = (w >> 20) * 128 + ((w >> 16) % 16);
      exp_q.push_back(8'(b)); s += b;
      b = (w >> 8) % 256;
      exp_q.push_back(8'(b)); s += b;
      b = w % 256;
      exp_q.push_back(8'(b)); s += b;
    end
    exp_q.push_back(8'((256 - s % 256) % 256));
    m_seq = m_seq + 8'd1;
    pend.delete();
  endtask

  // Capture model: predicts what the coming rising edge does with the inputs now present.
  always @(negedge clk) begin : cap_model
    int   lvl;
    logic evt;
    logic drop;
    if (rst) begin
      pend.delete();
      exp_q.delete();
      m_seq = 8'h00;
      pushed = 0;
      m_ovf = 1'b0;
      prev_dval = 1'b0;
      m_level_q <= 0;
    end else begin
      lvl = pushed - popped;
      chk("fifo_level", 32'(fifo_level), 32'(lvl));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      m_level_q <= lvl;
      evt = !in_dval && prev_dval;
      prev_dval = in_dval;
      drop = evt && (lvl == 16);
      if (drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      if (evt && !drop) begin
        pushed++;
        pend.push_back({in_phase, in_data});
        if (pend.size() == 4) gen_frame();
      end
    end
  end

  // Monitor: pops expected bytes on each accepted byte and checks stall/timing rules.
  always @(negedge clk) begin : monitor
    if (rst) begin
      pos = 0;
      frames_done = 0;
      fsum = 0;
      popped <= 0;
      prev_stall = 1'b0;
      prev_valid = 1'b0;
      after_csum = 1'b0;
    end else begin
      chk("frame_seq", 32'(frame_seq), 32'(frames_done % 256));
      if (prev_stall) begin
        chk("stall_valid", 32'(tx_valid), 32'd1);
        chk("stall_data", 32'(tx_data), 32'(prev_dat));
      end
      if (after_csum) chk("idle_gap", 32'(tx_valid), 32'd0);
      else if (!prev_valid) chk("start_latency", 32'(tx_valid), 32'(m_level_q >= 4));
      after_csum = 1'b0;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL tx_byte actual=%0h required=none t=%0t", tx_data, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            failures++;
            $display("FAIL tx_byte actual=%0h required=%0h pos=%0d t=%0t", tx_data, e, pos, $time);
          end
        end
        if (pos >= 1) fsum += int'(tx_data);
        if (pos == 1) begin
          if (saw_ff && tx_data == 8'h00) saw_wrap = 1'b1;
          saw_ff = (tx_data == 8'hFF);
        end
        if (pos >= 2 && pos <= 13 && (pos - 2) % 3 == 2) popped <= popped + 1;
        if (pos == 14) begin
          chk("frame_sum", 32'(fsum % 256), 32'd0);
          fsum = 0;
          pos = 0;
          frames_done++;
          after_csum = 1'b1;
        end else begin
          pos++;
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_dat = tx_data;
      prev_valid = tx_valid;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send_sample(input logic [19:0] d, input logic ph);
    @(posedge clk); #1;
    in_data = d;
    in_phase = ph;
    in_dval = 1'b0;
    @(posedge clk); #1;
    in_dval = 1'b1;
    repeat (14) @(posedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    @(posedge clk); #1;
    while ((exp_q.size() != 0 || tx_valid) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 5000) begin
      failures++;
      $display("FAIL %s drain timeout pending=%0d required=0", name, exp_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_seq", 32'(frame_seq), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed frame of four 0x00001 samples.
    ready_mode = 1;
    base = got_q.size();
    repeat (4) send_sample(20'h00001, 1'b0);
    wait_drain("t1");
    for (int i = 0; i < 15; i++) begin
      if (got_q.size() > base + i) chk("t1_byte", 32'(got_q[base + i]), 32'(t1_bytes[i]));
      else chk("t1_count", 32'(got_q.size() - base), 32'd15);
    end
    chk("t1_seq", 32'(frame_seq), 32'd1);

    // Phase flag and format in the next frame.
    base = got_q.size();
    send_sample(20'h12345, 1'b1);
    repeat (3) send_sample(20'($urandom), 1'($urandom));
    wait_drain("t2");
    if (got_q.size() >= base + 5) begin
      chk("t2_seq", 32'(got_q[base + 1]), 32'h01);
      chk("t2_b0", 32'(got_q[base + 2]), 32'h81);
      chk("t2_b1", 32'(got_q[base + 3]), 32'h23);
      chk("t2_b2", 32'(got_q[base + 4]), 32'h45);
    end else begin
      chk("t2_count", 32'(got_q.size() - base), 32'd15);
    end

    // Three samples are not enough to start a frame.
    repeat (3) send_sample(20'($urandom), 1'($urandom));
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("t2_partial_valid", 32'(tx_valid), 32'd0);
    chk("t2_partial_level", 32'(fifo_level), 32'd3);
    send_sample(20'($urandom), 1'($urandom));
    wait_drain("t2b");

    // Random backpressure.
    ready_mode = 2;
    repeat (4) send_sample(20'h00001, 1'b0);
    repeat (8) send_sample(20'($urandom), 1'($urandom));
    wait_drain("t3");

    // Overflow with the sink blocked.
    ready_mode = 0;
    for (int i = 0; i < 17; i++) send_sample(20'($urandom), 1'($urandom));
    @(negedge clk);
    chk("t4_ovf", 32'(ovf), 32'd1);
    chk("t4_level", 32'(fifo_level), 32'd16);
    @(posedge clk); #1;
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    @(negedge clk);
    chk("t4_clr_ovf", 32'(ovf), 32'd0);
    ready_mode = 1;
    wait_drain("t4");

    // Reset in the middle of a frame, with in_dval low at release.
    ready_mode = 0;
    repeat (4) send_sample(20'($urandom), 1'($urandom));
    ready_mode = 2;
    n = 0;
    while (pos < 5 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL t5_midframe timeout pos=%0d required=5", pos);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    in_dval = 1'b0;
    #1;
    chk("t5_valid", 32'(tx_valid), 32'd0);
    chk("t5_level", 32'(fifo_level), 32'd0);
    chk("t5_seq", 32'(frame_seq), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t5_no_sample", 32'(fifo_level), 32'd0);
    chk("t5_idle", 32'(tx_valid), 32'd0);
    @(posedge clk); #1;
    in_dval = 1'b1;

    // Long random run covering the sequence wrap.
    ready_mode = 2;
    for (int i = 0; i < 257 * 4; i++) send_sample(20'($urandom), 1'($urandom));
    wait_drain("t6");
    chk("t6_seq_wrap", 32'(saw_wrap), 32'd1);
    chk("t6_seq_final", 32'(frame_seq), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
